// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI byte-stream to register-bus bridge; burst address increment under SPI_REG_CTRL_AUTOINC_EN
// Command byte {rd, addr[6:0]} selects a register; following bytes are write data or read triggers.
module spi_reg_ctrl #(
   parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   input  logic       i_SPI_CS_n,
   output logic [6:0] o_Reg_Addr,
   output logic       o_Reg_Wr,
   output logic [7:0] o_Reg_WData,
   output logic       o_Reg_Rd,
   input  logic [7:0] i_Reg_RData,
   output logic       o_Busy
);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

   state_t     state_q, state_d;
   logic       cs_meta_q, cs_s_q;
   logic [6:0] addr_q, addr_d, addr_inc;
   logic [6:0] reg_addr_q, reg_addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       wr_q, wr_d, rd_q, rd_d;
   logic       idle_entry_q, stat_q, rd_tx_q;
   logic [7:0] tx_byte_q;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   assign addr_inc = addr_q + 7'd1;
`else
   assign addr_inc = addr_q;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cs_meta_q <= 1'b1;
         cs_s_q    <= 1'b1;
      end else begin
         cs_meta_q <= i_SPI_CS_n;
         cs_s_q    <= cs_meta_q;
      end
   end

   // A byte arriving as CS deasserts still completes a write, but no new read is started.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!cs_s_q) state_d = CMD;
         end
         CMD: begin
            if (i_RX_DV) begin
               addr_d = i_RX_Byte[6:0];
               if (i_RX_Byte[7]) begin
                  state_d    = RDATA;
                  rd_d       = !cs_s_q;
                  reg_addr_d = i_RX_Byte[6:0];
               end else begin
                  state_d = WDATA;
               end
            end
         end
         WDATA: begin
            if (i_RX_DV) begin
               wr_d       = 1'b1;
               reg_addr_d = addr_q;
               wdata_d    = i_RX_Byte;
               addr_d     = addr_inc;
            end
         end
         RDATA: begin
            if (i_RX_DV) begin
               addr_d     = addr_inc;
               rd_d       = !cs_s_q;
               reg_addr_d = addr_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cs_s_q) state_d = IDLE;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q      <= IDLE;
         addr_q       <= 7'd0;
         reg_addr_q   <= 7'd0;
         wdata_q      <= 8'd0;
         wr_q         <= 1'b0;
         rd_q         <= 1'b0;
         idle_entry_q <= 1'b1;
         stat_q       <= 1'b0;
         rd_tx_q      <= 1'b0;
         tx_byte_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         reg_addr_q   <= reg_addr_d;
         wdata_q      <= wdata_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         idle_entry_q <= (state_d == IDLE) && (state_q != IDLE);
         stat_q       <= idle_entry_q;
         // Read data is forwarded only if the transaction is still open.
         rd_tx_q      <= rd_q && !cs_s_q && (state_q != IDLE);
         if (idle_entry_q) begin
            tx_byte_q <= STATUS_BYTE;
         end else if (rd_tx_q) begin
            tx_byte_q <= i_Reg_RData;
         end
      end
   end

   assign o_TX_DV     = stat_q | rd_tx_q;
   assign o_TX_Byte   = rd_tx_q ? i_Reg_RData : tx_byte_q;
   assign o_Reg_Addr  = reg_addr_q;
   assign o_Reg_Wr    = wr_q;
   assign o_Reg_WData = wdata_q;
   assign o_Reg_Rd    = rd_q;
   assign o_Busy      = ~cs_s_q;

endmodule
